// File: rtl/program_loader.sv
// program_loader: boot loader that assembles big-endian words from a host byte stream into instruction memory.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the ERROR outcome.
`default_nettype none

module program_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              cpu_rst_o,
    output logic              cpu_enable_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int BPW  = WORD_W / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_FLUSH  = 3'd3,
        S_RUN    = 3'd4,
        S_ERROR  = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK = 3'd6
`endif
    } state_e;

    state_e state_q, state_d;

    logic              byte_ready_q, mem_we_q, cpu_run_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic [WORD_W-1:0] asm_q;
    logic [8:0]        count_q;
    logic [8:0]        word_idx_q;
    logic [BC_W-1:0]   byte_cnt_q;

    logic              accept;
    logic              word_end;
    logic              last_word;
    logic [WORD_W-1:0] asm_d;

    assign accept    = byte_ready_q & byte_valid_i;
    assign word_end  = (byte_cnt_q == LAST_BYTE);
    assign last_word = (word_idx_q == (count_q - 9'd1));
    assign asm_d     = (asm_q << 8) | WORD_W'(byte_data_i);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       error_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_HEADER;
            S_HEADER: if (accept) state_d = S_DATA;
            S_DATA: begin
                if (accept && word_end && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_FLUSH;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_d = (byte_data_i == xor_q) ? S_FLUSH : S_ERROR;
            end
`endif
            S_FLUSH:  state_d = S_RUN;
            S_RUN:    if (start_i) state_d = S_HEADER;
            S_ERROR:  if (start_i) state_d = S_HEADER;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            cpu_run_q    <= 1'b0;
        end else begin
            byte_ready_q <= (state_d == S_HEADER) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state_d == S_CHECK)
`endif
                            ;
            busy_q       <= (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_FLUSH)
`ifdef LOADER_CHECKSUM_EN
                            || (state_d == S_CHECK)
`endif
                            ;
            cpu_run_q    <= (state_d == S_RUN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            asm_q       <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept && (state_q == S_HEADER)) begin
                count_q    <= {1'b0, byte_data_i} + 9'd1;
                word_idx_q <= '0;
                byte_cnt_q <= '0;
            end else if (accept && (state_q == S_DATA)) begin
                asm_q <= asm_d;
                if (word_end) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= word_idx_q[ADDR_W-1:0];
                    mem_wdata_q <= asm_d;
                    word_idx_q  <= word_idx_q + 9'd1;
                    byte_cnt_q  <= '0;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR seeds with the header byte and folds in every payload byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xor_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            error_q <= (state_d == S_ERROR);
            if (accept && (state_q == S_HEADER)) begin
                xor_q <= byte_data_i;
            end else if (accept && (state_q == S_DATA)) begin
                xor_q <= xor_q ^ byte_data_i;
            end
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_rst_o    = cpu_run_q;
    assign cpu_enable_o = cpu_run_q;
    assign busy_o       = busy_q;
    assign done_o       = cpu_run_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader against a stream/word reference model.
`default_nettype none

module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, mem_we, cpu_rst, cpu_enable, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    program_loader #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .cpu_rst_o    (cpu_rst),
        .cpu_enable_o (cpu_enable),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]  cap_a[$];
    logic [31:0] cap_d[$];
    logic [31:0] img[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            cap_a.push_back(mem_addr);
            cap_d.push_back(mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   waited = 0;
        logic rdy;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                tests++;
                fails++;
                $display("FAIL byte_accept_timeout: byte %02h not accepted within 20 cycles", b);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    // Builds the byte stream for img[] and checks writes and final status.
    task automatic run_load(input bit gapped, input bit bad_ck, input bit mid_start);
        int         n = img.size();
        logic [7:0] st[$];
        logic [7:0] ck = 8'd0;
        int         h_cyc = 0;
        int         lat;
        int         exp_lat;
        st.push_back(8'(n - 1));
        foreach (img[k]) begin
            st.push_back(img[k][31:24]);
            st.push_back(img[k][23:16]);
            st.push_back(img[k][15:8]);
            st.push_back(img[k][7:0]);
        end
        foreach (st[k]) ck = ck ^ st[k];
        cap_a.delete();
        cap_d.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < st.size(); i++) begin
            if (gapped && i > 0) begin
                int g = $urandom_range(0, 2);
                if (mid_start && i == 6) g = 1;
                byte_valid = 1'b0;
                repeat (g) begin
                    if (mid_start && i == 6) start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            send_byte(st[i]);
            if (i == 0) h_cyc = cyc;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_ck ? ~ck : ck);
        @(negedge clk);
        tests++;
        if (bad_ck) begin
            if ({error, cpu_rst, done, cpu_enable, busy} !== 5'b10000) begin
                fails++;
                $display("FAIL bad_checksum_status: err/rst/done/en/busy=%b want 10000",
                         {error, cpu_rst, done, cpu_enable, busy});
            end
        end else if ({busy, done, mem_we} !== 3'b100) begin
            fails++;
            $display("FAIL flush_status: busy/done/we=%b want 100", {busy, done, mem_we});
        end
`else
        @(negedge clk);
        tests++;
        if ({mem_we, mem_addr, busy, done} !== {1'b1, 8'(n - 1), 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL flush_final_write: we/addr/busy/done=%b/%0d/%b/%b want 1/%0d/1/0",
                     mem_we, mem_addr, busy, done, n - 1);
        end
`endif
        if (!bad_ck) begin
            @(negedge clk);
            tests++;
            if ({done, cpu_rst, cpu_enable, busy, error, byte_ready} !== 6'b111000) begin
                fails++;
                $display("FAIL run_status: done/rst/en/busy/err/rdy=%b want 111000",
                         {done, cpu_rst, cpu_enable, busy, error, byte_ready});
            end
            if (!gapped) begin
                // Cycles after the header edge up to and including the first RUN cycle.
                lat = cyc - h_cyc + 1;
`ifdef LOADER_CHECKSUM_EN
                exp_lat = 4 * n + 3;
`else
                exp_lat = 4 * n + 2;
`endif
                tests++;
                if (lat != exp_lat) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles want %0d", lat, exp_lat);
                end
            end
        end
        tests++;
        if (cap_a.size() != n) begin
            fails++;
            $display("FAIL write_count: got %0d want %0d", cap_a.size(), n);
        end
        for (int i = 0; i < n && i < cap_a.size(); i++) begin
            tests++;
            if (cap_a[i] !== 8'(i) || cap_d[i] !== img[i]) begin
                fails++;
                $display("FAIL write_%0d: got addr %0d data %08h want addr %0d data %08h",
                         i, cap_a[i], cap_d[i], i, img[i]);
            end
        end
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, cpu_enable, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: some output nonzero during reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
            tests++;
            if ({byte_ready, busy, done, cpu_rst} !== 4'b0000) begin
                fails++;
                $display("FAIL idle_no_accept: rdy/busy/done/rst=%b want 0000",
                         {byte_ready, busy, done, cpu_rst});
            end
        end
        byte_valid = 1'b0;
        tests++;
        if (cap_a.size() != 0) begin
            fails++;
            $display("FAIL idle_no_write: got %0d writes want 0", cap_a.size());
        end
    endtask

    task automatic test_single_word();
        img.delete();
        img.push_back(32'h12345678);
        run_load(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_checksum();
        img.delete();
        img.push_back(32'hAABBCCDD);
        img.push_back(32'h11223344);
        run_load(1'b0, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        run_load(1'b0, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_gapped();
        random_image(4);
        run_load(1'b1, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            random_image($urandom_range(1, 8));
            run_load(r[0], 1'b0, 1'b0);
        end
    endtask

    task automatic test_full_image();
        img.delete();
        for (int k = 0; k < 256; k++)
            img.push_back({8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
        run_load(1'b0, 1'b0, 1'b0);
        tests++;
        if (cap_d.size() != 256 || cap_d[255] !== 32'hFCFDFEFF || cap_a[255] !== 8'hFF) begin
            fails++;
            $display("FAIL full_last_word: got %0d writes, last %08h want 256 writes, last FCFDFEFF",
                     cap_d.size(), (cap_d.size() > 0) ? cap_d[cap_d.size() - 1] : 32'h0);
        end
    endtask

    task automatic test_reload();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({cpu_enable, cpu_rst, done, busy, byte_ready} !== 5'b00011) begin
            fails++;
            $display("FAIL reload_release: en/rst/done/busy/rdy=%b want 00011",
                     {cpu_enable, cpu_rst, done, busy, byte_ready});
        end
        random_image(3);
        run_load(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midload();
        random_image(6);
        cap_a.delete();
        cap_d.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            send_byte(img[i][31:24]);
            send_byte(img[i][23:16]);
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, cpu_enable, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: some output nonzero right after rst assert");
        end
        tests++;
        if (cap_a.size() != 3) begin
            fails++;
            $display("FAIL midload_writes: got %0d writes want 3", cap_a.size());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        random_image(3);
        run_load(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_checksum();
        test_gapped();
        test_full_image();
        test_reload();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
